hex_nibble_scanner: RTL
=======================

Name: hex_nibble_scanner

Overview:
- Downstream display stage: consumes the 8-bit result of the switch/adder stage and drives the single on-board 7-segment digit.
- Shows the byte as two hex digits in alternation on one digit: high nibble with decimal point lit, then low nibble with decimal point dark.
- A blank gap separates the two digits.
- Dwell time per digit is set by MAX_COUNT. At the default 10 MHz clock this gives 1 s per digit.

Parameters:
- MAX_COUNT, 24'd10_000_000, clock cycles each digit is shown; legal range 1..2^24-1.
- BLANK_COUNT, 24'd1_000_000, clock cycles of blank between digits; 0 removes the gaps.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- value_in  input  8  byte to display; sampled only at snapshot points.
- freeze  input  1  when high, hold the current state, timer and snapshot.
- seg_out  output  8  segments, active-high. Bit0=a … bit6=g, bit7=dp.
- phase_hi  output  1  high while in SHOW_HI.
- digit_start  output  1  one-cycle pulse on the first cycle of SHOW_HI or SHOW_LO.

Behaviour:
- Architecture:
  - One clock, synchronous active-high reset.
  - Registers: state (2 bits), timer (24 bits), snap (8 bits), start_flag.
  - seg_out, phase_hi and digit_start decode combinationally from these registers; no extra output latency.
- States and outputs:
  - SHOW_HI: seg_out = font(snap[7:4]) | 8'h80.
  - GAP1: seg_out = 8'h00.
  - SHOW_LO: seg_out = font(snap[3:0]), bit7 = 0.
  - GAP2: seg_out = 8'h00.
- Transitions:
  - In SHOW_*, when timer == MAX_COUNT-1: timer <= 0 and advance. SHOW_HI goes to GAP1; SHOW_LO goes to GAP2.
  - In GAP*, when timer == BLANK_COUNT-1: timer <= 0 and advance. GAP1 goes to SHOW_LO; GAP2 goes to SHOW_HI.
  - Otherwise timer <= timer+1.
  - If BLANK_COUNT == 0, the GAP states are never entered: SHOW_HI goes directly to SHOW_LO, and SHOW_LO directly to SHOW_HI.
- Snapshot:
  - snap <= value_in on every clock where rst is high.
  - snap <= value_in on the clock edge that enters SHOW_HI (from GAP2, or from SHOW_LO when BLANK_COUNT == 0).
  - Both nibbles of one HI/LO pair therefore always come from the same byte.
  - value_in changes at any other time have no effect.
- Reset (any cycle, including mid-digit or mid-gap):
  - state <= SHOW_HI, timer <= 0, start_flag <= 1.
  - First post-reset cycle: seg_out = font(value_in@reset)|8'h80, phase_hi = 1, digit_start = 1.
- digit_start:
  - start_flag is set on the edge entering SHOW_HI or SHOW_LO, and cleared on the next non-frozen clock.
  - digit_start = start_flag.
- freeze:
  - All registers hold, so seg_out and phase_hi are static and digit_start stays at its current value.
  - rst overrides freeze.
- Font (hex 0..F):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07.
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Period:
  - 2*MAX_COUNT + 2*BLANK_COUNT cycles.
  - MAX_COUNT = 1 is legal: each digit shows for exactly one cycle.
- Timer compare width is 24 bits; the timer never exceeds the active limit minus 1.

Test Plan:
- MAX_COUNT=4, BLANK_COUNT=2; value_in=8'hA5, rst high 2 cycles then low → per-cycle seg_out:
  - cycles 0-3: F7 (SHOW_HI, digit A with dp)
  - cycles 4-5: 00 (GAP1)
  - cycles 6-9: 6D (SHOW_LO, digit 5)
  - cycles 10-11: 00 (GAP2)
  - then repeats
  - digit_start high at cycles 0 and 6 only.
- Snapshot coherence:
  - Change value_in to 8'h3C at cycle 5 → cycles 6-9 still show 6D.
  - From cycle 12: SHOW_HI shows CF (3 with dp), then SHOW_LO shows 39 (C).
- BLANK_COUNT=0, MAX_COUNT=1; value_in=8'h0F → seg_out alternates BF, 71 every cycle; phase_hi toggles every cycle.
- freeze high for 5 cycles during SHOW_LO at timer=1 → seg_out is held for those cycles; after release, 3 more SHOW_LO cycles, then GAP2.
- rst asserted mid-GAP1 with value_in=8'hE2 → next cycle seg_out=F9 (E with dp), phase_hi=1, digit_start=1, timer=0.
- Sweep all 16 nibble values via value_in = {n,n} → SHOW_HI and SHOW_LO seg_out match the font table (HI additionally with bit7 set).

Source files
------------

// File: rtl/hex_nibble_scanner_if.sv
// Display-stage bus: byte to show plus freeze in,
// segment drive and phase/start status out.
interface hex_nibble_scanner_if;
  logic [7:0] value_in;
  logic       freeze;
  logic [7:0] seg_out;
  logic       phase_hi;
  logic       digit_start;

  modport master (
    output value_in, freeze,
    input  seg_out, phase_hi, digit_start
  );

  modport slave (
    input  value_in, freeze,
    output seg_out, phase_hi, digit_start
  );
endinterface

// File: rtl/hex_nibble_scanner.sv
// Single 7-segment digit scanner: shows a byte as
// high nibble (dp lit), gap, low nibble, gap.
module hex_nibble_scanner #(
  parameter logic [23:0] MAX_COUNT   = 24'd10_000_000,
  parameter logic [23:0] BLANK_COUNT = 24'd1_000_000
) (
  input logic clk,
  input logic rst,
  hex_nibble_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    SHOW_HI,
    GAP1,
    SHOW_LO,
    GAP2
  } state_t;

  localparam logic [23:0] SHOW_LIM = MAX_COUNT - 24'd1;
  localparam logic [23:0] GAP_LIM  = BLANK_COUNT - 24'd1;
  localparam logic        NO_GAP   = (BLANK_COUNT == 24'd0);

  state_t      r_state;
  logic [23:0] r_timer;
  logic [7:0]  r_snap;
  logic        r_start;

  state_t      w_state_nxt;
  logic [23:0] w_timer_nxt;
  logic [7:0]  w_snap_nxt;
  logic        w_start_nxt;
  logic        w_show;
  logic [23:0] w_lim;
  logic [6:0]  w_font;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SHOW_HI;
      r_timer <= 24'd0;
      r_snap  <= bus.value_in;
      r_start <= 1'b1;
    end else if (!bus.freeze) begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_snap  <= w_snap_nxt;
      r_start <= w_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 24'd1;
    w_snap_nxt  = r_snap;
    w_start_nxt = 1'b0;
    w_show = (r_state == SHOW_HI) || (r_state == SHOW_LO);
    w_lim  = w_show ? SHOW_LIM : GAP_LIM;
    if (r_timer == w_lim) begin
      w_timer_nxt = 24'd0;
      unique case (r_state)
        SHOW_HI: w_state_nxt = NO_GAP ? SHOW_LO : GAP1;
        GAP1:    w_state_nxt = SHOW_LO;
        SHOW_LO: w_state_nxt = NO_GAP ? SHOW_HI : GAP2;
        GAP2:    w_state_nxt = SHOW_HI;
      endcase
      w_start_nxt = (w_state_nxt == SHOW_HI) ||
                    (w_state_nxt == SHOW_LO);
      // both nibbles of a pair come from this one capture
      if (w_state_nxt == SHOW_HI) w_snap_nxt = bus.value_in;
    end
  end

  always_comb begin
    w_font      = 7'h00;
    bus.seg_out = 8'h00;
    unique case (r_state)
      SHOW_HI: begin
        w_font      = font(r_snap[7:4]);
        bus.seg_out = {1'b1, w_font};
      end
      SHOW_LO: begin
        w_font      = font(r_snap[3:0]);
        bus.seg_out = {1'b0, w_font};
      end
      GAP1, GAP2: bus.seg_out = 8'h00;
    endcase
  end

  assign bus.phase_hi    = (r_state == SHOW_HI);
  assign bus.digit_start = r_start;

endmodule
